// File: rtl/instruction_fetch_ram_pkg.sv
// Shared definitions for the instruction fetch RAM: sequencer state encoding
// and the builder for the default END_OF_PROGRAM terminator word.
package instruction_fetch_ram_pkg;

   localparam logic [1:0] IDLE_ENC    = 2'd0;
   localparam logic [1:0] FETCH_ENC   = 2'd1;
   localparam logic [1:0] PRESENT_ENC = 2'd2;
   localparam logic [1:0] DONE_ENC    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = IDLE_ENC,
      FETCH   = FETCH_ENC,
      PRESENT = PRESENT_ENC,
      DONE    = DONE_ENC
   } fetch_state_e;

   // All-ones mask of the requested width, truncated by the caller to DATA_WIDTH.
   function automatic logic [63:0] eop_default(input int unsigned width);
      logic [63:0] mask;
      if (width >= 32'd64) begin
         mask = {64{1'b1}};
      end else begin
         mask = (64'd1 << width) - 64'd1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/instruction_fetch_ram_if.sv
// Valid/ready channel carrying fetched instructions from the sequencer to the
// controller; master is the fetch unit, slave is the consumer.
interface instruction_fetch_ram_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr_data;
   logic [ADDR_WIDTH-1:0] instr_addr;

   modport master (
      output instr_valid,
      output instr_data,
      output instr_addr,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_data,
      input  instr_addr,
      output instr_ready
   );
endinterface

// File: rtl/instruction_fetch_ram_instr_mem_array.sv
// Instruction storage: one bounds-checked write port and one registered read
// port. Contents survive reset so a program can be rerun without reloading.
module instr_mem_array #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  wr_in_range_s;
   logic                  rd_in_range_s;

   assign wr_in_range_s = ({1'b0, waddr_i} < DEPTH_W);
   assign rd_in_range_s = ({1'b0, raddr_i} < DEPTH_W);

   always_ff @(posedge clk) begin
      if (we_i && wr_in_range_s) begin
         mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
      end
   end

   // Read-before-write: a same-edge write to raddr_i is seen one cycle later.
   always_ff @(posedge clk) begin
      if (rd_in_range_s) begin
         rdata_q <= mem_q[raddr_i[IDX_W-1:0]];
      end else begin
         rdata_q <= {DATA_WIDTH{1'b0}};
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch_ram.sv
// Writable instruction memory with a fetch sequencer that walks the program
// from address 0 and hands each word to the controller over valid/ready.
module instruction_fetch_ram
   import instruction_fetch_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    DEPTH          = 16,
   parameter int                    ADDR_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0] END_OF_PROGRAM = DATA_WIDTH'(eop_default(DATA_WIDTH))
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   instruction_fetch_ram_if.master fetch_if,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  prime_q, prime_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  mem_we_s;
   logic [DATA_WIDTH-1:0] rd_data_s;

   assign mem_we_s = wr_en && ((state_q == IDLE) || (state_q == DONE));

   // Read address follows pc_d so the word for the next FETCH is ready on entry.
   instr_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we_s),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (pc_d),
      .rdata_o (rd_data_s)
   );

   // The first FETCH of a run spends one priming cycle re-reading address 0,
   // so a write landing on the start edge is visible to that fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      data_d  = data_q;
      prime_d = prime_q;
      valid_d = valid_q;
      done_d  = done_q;
      error_d = error_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = FETCH;
               pc_d    = {ADDR_WIDTH{1'b0}};
               prime_d = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         FETCH: begin
            if (prime_q) begin
               prime_d = 1'b0;
            end else begin
               data_d = rd_data_s;
               addr_d = pc_q;
               if (rd_data_s == END_OF_PROGRAM) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  error_d = 1'b0;
                  state_d = DONE;
               end else begin
                  valid_d = 1'b1;
                  state_d = PRESENT;
               end
            end
         end
         PRESENT: begin
            if (fetch_if.instr_ready) begin
               valid_d = 1'b0;
               if (pc_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  error_d = 1'b1;
                  state_d = DONE;
               end else begin
                  pc_d    = pc_q + ADDR_WIDTH'(1);
                  state_d = FETCH;
               end
            end else begin
               state_d = PRESENT;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d == FETCH) || (state_d == PRESENT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= {ADDR_WIDTH{1'b0}};
         addr_q  <= {ADDR_WIDTH{1'b0}};
         data_q  <= {DATA_WIDTH{1'b0}};
         prime_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         prime_q <= prime_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign fetch_if.instr_valid = valid_q;
   assign fetch_if.instr_data  = data_q;
   assign fetch_if.instr_addr  = addr_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign error                = error_q;

endmodule

// File: doc/instruction_fetch_ram.md
Name: instruction_fetch_ram

Overview:
Parametrised, writable instruction memory with an integrated fetch sequencer. It replaces the fixed, combinationally read instruction store. After a start pulse it walks the program from address 0 and presents one instruction per handshake to the controller over a valid/ready interface. It stops on the END_OF_PROGRAM word, or flags an error if it runs off the end of memory.

Parameters:
DATA_WIDTH, 8, instruction word width in bits.
DEPTH, 16, number of instruction words; must be at least 2.
ADDR_WIDTH, 8, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
END_OF_PROGRAM, all ones ({DATA_WIDTH{1'b1}}), terminator word; it is never presented to the consumer.

Ports:
clk  input  1  single clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset.
wr_en  input  1  program-load write strobe.
wr_addr  input  ADDR_WIDTH  program-load address.
wr_data  input  DATA_WIDTH  program-load data.
start  input  1  begins a fetch run from address 0.
instr_ready  input  1  consumer accepts the presented instruction.
instr_valid  output  1  instr_data and instr_addr are valid.
instr_data  output  DATA_WIDTH  presented instruction word.
instr_addr  output  ADDR_WIDTH  address of the presented word.
busy  output  1  a fetch run is in progress (FETCH or PRESENT).
done  output  1  run finished; held high until the next start or reset.
error  output  1  run ended without finding END_OF_PROGRAM; valid only while done=1.

Behaviour:
- Reset (synchronous): state=IDLE, pc=0, instr_valid=0, instr_data=0, instr_addr=0, busy=0, done=0, error=0. Memory contents are not cleared.
- Writes:
  - mem[wr_addr] <= wr_data on a clock edge with wr_en=1 and state IDLE or DONE.
  - Ignored while busy=1.
  - Ignored when wr_addr >= DEPTH.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE or DONE with start=1: pc<=0, done<=0, error<=0, go to FETCH.
- start in FETCH or PRESENT is ignored.
- FETCH (one cycle): read mem[pc] synchronously; instr_data<=mem[pc], instr_addr<=pc.
  - If mem[pc] == END_OF_PROGRAM: instr_valid<=0, done<=1, error<=0, go to DONE.
  - Otherwise: instr_valid<=1, go to PRESENT.
- PRESENT: instr_valid=1; instr_data and instr_addr are held stable until instr_valid && instr_ready.
  - On acceptance with pc == DEPTH-1: instr_valid<=0, done<=1, error<=1, go to DONE.
  - On any other acceptance: instr_valid<=0, pc<=pc+1, go to FETCH.
- Latency: start sampled at edge N gives instr_valid=1 after edge N+2. With instr_ready held at 1, the peak rate is one instruction every 2 cycles.
- busy=1 exactly in FETCH and PRESENT.
- done and error are registered and change only on the transitions above, start, or reset.
- A write to the address currently being fetched cannot occur (writes are blocked while busy).
- A write and a start on the same edge while in IDLE or DONE: the write completes and the run starts. The first FETCH reads the updated memory.
- instr_ready while instr_valid=0 has no effect.
- Reset mid-run aborts the run immediately, with all outputs at their reset values on the next cycle. Memory is preserved, so a following start reruns the same program.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE/FETCH/PRESENT/DONE) and the default END_OF_PROGRAM constant builder.
- Sub-module instr_mem_array (DATA_WIDTH, DEPTH, ADDR_WIDTH): single write port, synchronous read port, bounds-checked write, no reset. The sequencer FSM stays in instruction_fetch_ram.

Test Plan:
- Load 4, 3, 8, 5, 8'hFF at addresses 0-4, pulse start at edge 0, hold instr_ready=1 -> valid after edges 2/4/6/8 with data 4/3/8/5 and addr 0/1/2/3. done=1, error=0 after edge 10; busy falls at the same edge.
- Same program, instr_ready=0 for 3 cycles while word 3 (addr 1) is presented -> instr_valid and data=3 held stable for those cycles. Word 8 follows 2 cycles after ready rises.
- mem[0]=8'hFF, start -> instr_valid never asserts; done=1, error=0 two cycles after start.
- DEPTH=16, all words 8'h01, start with ready=1 -> exactly 16 valid words at addr 0-15, then done=1, error=1.
- While busy, wr_en=1 with wr_addr=2, wr_data=8'h77 -> ignored. A second run still presents the original 8 at addr 2.
- Reset asserted during PRESENT of addr 1 -> next cycle all outputs are at reset values. A later start replays 4, 3, 8, 5. A write with wr_addr=DEPTH leaves memory unchanged.
